// File: rtl/uart_cmd_scheduler_if.sv
// Byte-stream and channel-load signal bundle for uart_cmd_scheduler.
// The master side is the scheduler; the slave side is the UART and channel fabric.
interface uart_cmd_scheduler_if #(
  parameter int DATA_BIT   = 32,
  parameter int OUTPUT_NUM = 16
);
  logic [7:0]            rx_data_i;
  logic                  rx_done_tick_i;
  logic                  tx_start_o;
  logic [7:0]            tx_data_o;
  logic                  tx_done_tick_i;
  logic [OUTPUT_NUM-1:0] ch_load_o;
  logic [DATA_BIT-1:0]   ch_pattern_o;
  logic [7:0]            ch_ctrl_o;
  logic                  timeout_o;
  logic                  overrun_o;

  modport master (
    input  rx_data_i, rx_done_tick_i, tx_done_tick_i,
    output tx_start_o, tx_data_o, ch_load_o, ch_pattern_o, ch_ctrl_o,
    timeout_o, overrun_o
  );

  modport slave (
    output rx_data_i, rx_done_tick_i, tx_done_tick_i,
    input  tx_start_o, tx_data_o, ch_load_o, ch_pattern_o, ch_ctrl_o,
    timeout_o, overrun_o
  );
endinterface

// File: rtl/uart_cmd_scheduler.sv
// Decodes A5-framed UART command packets into one-hot channel pattern loads
// and answers each packet with an ACK (0x06) or NAK (0x15) byte.
module uart_cmd_scheduler #(
  parameter int DATA_BIT    = 32,
  parameter int OUTPUT_NUM  = 16,
  parameter int TIMEOUT_CLK = 100_000
) (
  input  logic clk_i,
  input  logic rst_i,
  uart_cmd_scheduler_if.master bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CHAN    = 3'd1;
  localparam logic [2:0] DATA    = 3'd2;
  localparam logic [2:0] CTRL    = 3'd3;
  localparam logic [2:0] CSUM    = 3'd4;
  localparam logic [2:0] LOAD    = 3'd5;
  localparam logic [2:0] ACK     = 3'd6;
  localparam logic [2:0] WAIT_TX = 3'd7;

  localparam int         BYTES    = DATA_BIT / 8;
  localparam int         BCNT_W   = $clog2(BYTES + 1);
  localparam int         TMO_W    = $clog2(TIMEOUT_CLK + 1);
  localparam logic [7:0] HEADER   = 8'hA5;
  localparam logic [7:0] ACK_BYTE = 8'h06;
  localparam logic [7:0] NAK_BYTE = 8'h15;

  logic [2:0]            state;
  logic [7:0]            chan;
  logic [7:0]            ctrl;
  logic [7:0]            csum;
  logic [DATA_BIT-1:0]   pattern;
  logic [BCNT_W-1:0]     byte_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  pkt_ok;

  logic                  in_pkt;
  logic                  busy;
  logic                  rx;
  logic                  tmo_hit;
  logic                  csum_ok;
  logic [OUTPUT_NUM-1:0] onehot;

  always_comb begin
    rx      = bus.rx_done_tick_i;
    in_pkt  = state inside {CHAN, DATA, CTRL, CSUM};
    busy    = state inside {LOAD, ACK, WAIT_TX};
    // A byte arriving on the terminal count wins over the timeout.
    tmo_hit = in_pkt && !rx && (tmo_cnt == TMO_W'(TIMEOUT_CLK - 1));
    csum_ok = (csum == bus.rx_data_i) && ({1'b0, chan} < 9'(OUTPUT_NUM));
    onehot  = OUTPUT_NUM'(1) << chan;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      chan             <= '0;
      ctrl             <= '0;
      csum             <= '0;
      pattern          <= '0;
      byte_cnt         <= '0;
      tmo_cnt          <= '0;
      pkt_ok           <= 1'b0;
      bus.tx_start_o   <= 1'b0;
      bus.tx_data_o    <= '0;
      bus.ch_load_o    <= '0;
      bus.ch_pattern_o <= '0;
      bus.ch_ctrl_o    <= '0;
      bus.timeout_o    <= 1'b0;
      bus.overrun_o    <= 1'b0;
    end else begin
      bus.ch_load_o  <= '0;
      bus.tx_start_o <= 1'b0;
      bus.timeout_o  <= tmo_hit;
      bus.overrun_o  <= busy && rx;

      if (!in_pkt || rx || tmo_hit) tmo_cnt <= '0;
      else                          tmo_cnt <= tmo_cnt + TMO_W'(1);

      case (state)
        IDLE: begin
          if (rx && bus.rx_data_i == HEADER) state <= CHAN;
        end
        CHAN: begin
          if (rx) begin
            chan     <= bus.rx_data_i;
            csum     <= bus.rx_data_i;
            byte_cnt <= '0;
            state    <= DATA;
          end else if (tmo_hit) begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (rx) begin
            pattern  <= (pattern << 8) | DATA_BIT'(bus.rx_data_i);
            csum     <= csum ^ bus.rx_data_i;
            byte_cnt <= byte_cnt + BCNT_W'(1);
            if (byte_cnt == BCNT_W'(BYTES - 1)) state <= CTRL;
          end else if (tmo_hit) begin
            state <= IDLE;
          end
        end
        CTRL: begin
          if (rx) begin
            ctrl  <= bus.rx_data_i;
            csum  <= csum ^ bus.rx_data_i;
            state <= CSUM;
          end else if (tmo_hit) begin
            state <= IDLE;
          end
        end
        CSUM: begin
          if (rx) begin
            // Channel outputs are registered here so they appear during LOAD.
            pkt_ok <= csum_ok;
            if (csum_ok) begin
              bus.ch_load_o    <= onehot;
              bus.ch_pattern_o <= pattern;
              bus.ch_ctrl_o    <= ctrl;
            end
            state <= LOAD;
          end else if (tmo_hit) begin
            state <= IDLE;
          end
        end
        LOAD: begin
          bus.tx_start_o <= 1'b1;
          bus.tx_data_o  <= pkt_ok ? ACK_BYTE : NAK_BYTE;
          state          <= ACK;
        end
        ACK: begin
          state <= WAIT_TX;
        end
        WAIT_TX: begin
          if (bus.tx_done_tick_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed vector bench for uart_cmd_scheduler (DATA_BIT=32, OUTPUT_NUM=16, TIMEOUT_CLK=50).
module tb_uart_cmd_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  uart_cmd_scheduler_if #(.DATA_BIT(32), .OUTPUT_NUM(16)) bus ();

  uart_cmd_scheduler #(
    .DATA_BIT   (32),
    .OUTPUT_NUM (16),
    .TIMEOUT_CLK(50)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic [7:0]  chan;
    logic [31:0] pat;
    logic [7:0]  ctrl;
    logic [7:0]  csum;
    logic [15:0] exp_load;
    logic [31:0] exp_pat;
    logic [7:0]  exp_ctrl;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_data_i      = b;
    bus.rx_done_tick_i = 1'b1;
    @(posedge clk); #1;
    bus.rx_done_tick_i = 1'b0;
  endtask

  task automatic tx_done();
    @(posedge clk); #1;
    bus.tx_done_tick_i = 1'b1;
    @(posedge clk); #1;
    bus.tx_done_tick_i = 1'b0;
  endtask

  task automatic run_pkt(input vec_t v, input bit overrun);
    logic [31:0] p;
    p = v.pat;
    send(8'hA5);
    send(v.chan);
    for (int i = 3; i >= 0; i--) send(p[i*8 +: 8]);
    send(v.ctrl);
    send(v.csum);
    @(negedge clk);
    chk({v.name, ".load"},    32'(bus.ch_load_o), 32'(v.exp_load));
    chk({v.name, ".pattern"}, bus.ch_pattern_o,   v.exp_pat);
    chk({v.name, ".ctrl"},    32'(bus.ch_ctrl_o), 32'(v.exp_ctrl));
    chk({v.name, ".txs_load"}, 32'(bus.tx_start_o), 32'd0);
    @(negedge clk);
    chk({v.name, ".tx_start"}, 32'(bus.tx_start_o), 32'd1);
    chk({v.name, ".tx_data"},  32'(bus.tx_data_o),  32'(v.exp_tx));
    chk({v.name, ".load_off"}, 32'(bus.ch_load_o),  32'd0);
    if (overrun) begin
      @(posedge clk); #1;
      bus.rx_data_i      = 8'h55;
      bus.rx_done_tick_i = 1'b1;
      @(posedge clk); #1;
      bus.rx_done_tick_i = 1'b0;
      @(negedge clk);
      chk({v.name, ".overrun"},  32'(bus.overrun_o),  32'd1);
      chk({v.name, ".tx_hold"},  32'(bus.tx_data_o),  32'(v.exp_tx));
      @(negedge clk);
      chk({v.name, ".overrun_off"}, 32'(bus.overrun_o), 32'd0);
    end else begin
      @(negedge clk);
      chk({v.name, ".tx_start_off"}, 32'(bus.tx_start_o), 32'd0);
    end
    tx_done();
  endtask

  initial begin
    int first_to;
    int to_pulses;
    int saw_tx;
    vec_t v7;

    //        name       chan   pattern       ctrl   csum   load      held pattern  ctrl   tx
    vecs[0] = '{"valid3",  8'h03, 32'h12345678, 8'h81, 8'h8A, 16'h0008, 32'h12345678, 8'h81, 8'h06};
    vecs[1] = '{"badsum",  8'h03, 32'h12345678, 8'h81, 8'h8B, 16'h0000, 32'h12345678, 8'h81, 8'h15};
    vecs[2] = '{"chan16",  8'h10, 32'h00000000, 8'h00, 8'h10, 16'h0000, 32'h12345678, 8'h81, 8'h15};
    vecs[3] = '{"chan15",  8'h0F, 32'hDEADBEEF, 8'h3C, 8'h11, 16'h8000, 32'hDEADBEEF, 8'h3C, 8'h06};
    vecs[4] = '{"a5data",  8'h00, 32'hA5A5A5A5, 8'hA5, 8'hA5, 16'h0001, 32'hA5A5A5A5, 8'hA5, 8'h06};
    vecs[5] = '{"chanFF",  8'hFF, 32'h00000000, 8'h00, 8'hFF, 16'h0000, 32'hA5A5A5A5, 8'hA5, 8'h15};
    v7      = '{"chan7",   8'h07, 32'h01020304, 8'h00, 8'h03, 16'h0080, 32'h01020304, 8'h00, 8'h06};

    bus.rx_data_i      = '0;
    bus.rx_done_tick_i = 1'b0;
    bus.tx_done_tick_i = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst.load",    32'(bus.ch_load_o),  32'd0);
    chk("rst.pattern", bus.ch_pattern_o,    32'd0);
    chk("rst.ctrl",    32'(bus.ch_ctrl_o),  32'd0);
    chk("rst.txs",     32'(bus.tx_start_o), 32'd0);
    chk("rst.txd",     32'(bus.tx_data_o),  32'd0);
    chk("rst.flags",   {30'd0, bus.timeout_o, bus.overrun_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-header bytes in IDLE must be dropped without a response.
    send(8'h55);
    send(8'h00);
    @(negedge clk);
    chk("idle.drop", {30'd0, bus.tx_start_o, bus.overrun_o}, 32'd0);

    for (int i = 0; i < 6; i++) run_pkt(vecs[i], 1'b0);

    // Inter-byte timeout: 50 idle clocks after the last byte.
    send(8'hA5);
    send(8'h05);
    send(8'h11);
    first_to  = 0;
    to_pulses = 0;
    saw_tx    = 0;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (bus.timeout_o) begin
        to_pulses++;
        if (first_to == 0) first_to = n;
      end
      if (bus.tx_start_o) saw_tx++;
    end
    chk("timeout.cycle",  32'(first_to),  32'd51);
    chk("timeout.pulses", 32'(to_pulses), 32'd1);
    chk("timeout.no_ack", 32'(saw_tx),    32'd0);
    run_pkt(vecs[0], 1'b0);

    // Byte during WAIT_TX, then a normal packet.
    run_pkt(vecs[3], 1'b1);
    run_pkt(vecs[4], 1'b0);

    // Reset in the middle of a packet.
    send(8'hA5);
    send(8'h07);
    send(8'hAA);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst.pattern", bus.ch_pattern_o,   32'd0);
    chk("midrst.ctrl",    32'(bus.ch_ctrl_o), 32'd0);
    chk("midrst.txd",     32'(bus.tx_data_o), 32'd0);
    repeat (2) @(negedge clk);
    chk("midrst.load", 32'(bus.ch_load_o),  32'd0);
    chk("midrst.txs",  32'(bus.tx_start_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_pkt(v7, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_cmd_scheduler.md
UART_CMD_SCHEDULER -- requirements
Module: uart_cmd_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_BIT, default 32, giving the pattern width; it is a multiple of 8.
REQ-002 The block SHALL have parameter OUTPUT_NUM, default 16, giving the number of serial output channels, 1..256.
REQ-003 The block SHALL have parameter TIMEOUT_CLK, default 100_000, giving the maximum idle clocks allowed between bytes of one packet.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port clk_i, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-006 Port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 Port rx_data_i, input, 8 bits: received UART byte, valid only when rx_done_tick_i=1.
REQ-008 Port rx_done_tick_i, input, 1 bit: one-cycle pulse, one byte received.
REQ-009 Port tx_start_o, output, 1 bit: one-cycle pulse requesting UART transmission of tx_data_o.
REQ-010 Port tx_data_o, output, 8 bits: acknowledge byte.
REQ-011 Port tx_done_tick_i, input, 1 bit: one-cycle pulse, UART transmission finished.
REQ-012 Port ch_load_o, input/output direction output, OUTPUT_NUM bits: one-hot one-cycle load strobe to the target channel.
REQ-013 Port ch_pattern_o, output, DATA_BIT bits: pattern for the loaded channel; held stable until the next load.
REQ-014 Port ch_ctrl_o, output, 8 bits: control byte for the loaded channel; held stable until the next load.
REQ-015 Port timeout_o, output, 1 bit: one-cycle pulse, packet abandoned by inter-byte timeout.
REQ-016 Port overrun_o, output, 1 bit: one-cycle pulse, byte arrived while the block could not accept it.

Function
REQ-017 The packet format SHALL be: header 0xA5; channel byte; DATA_BIT/8 pattern bytes, MSB first; control byte; checksum byte.
REQ-018 The checksum SHALL be the bitwise XOR of the channel, pattern and control bytes.
REQ-019 The FSM SHALL have states IDLE, CHAN, DATA, CTRL, CSUM, LOAD, ACK, WAIT_TX.
REQ-020 In IDLE, a byte of 0xA5 SHALL move the FSM to CHAN; any other byte SHALL be discarded silently.
REQ-021 Transitions on each accepted byte: CHAN->DATA; DATA->CTRL after DATA_BIT/8 bytes, counted by a byte counter cleared on entry; CTRL->CSUM; CSUM->LOAD.
REQ-022 The packet SHALL be valid only if the checksum matches and channel < OUTPUT_NUM.
REQ-023 LOAD SHALL last one cycle, beginning the cycle after the checksum byte's rx_done_tick_i.
  - Valid packet: ch_load_o[channel]=1; ch_pattern_o and ch_ctrl_o updated in the same cycle.
  - Invalid packet: ch_load_o stays 0 and the outputs are unchanged.
REQ-024 ACK SHALL last one cycle and assert tx_start_o=1.
  - tx_data_o=0x06 for a valid packet, 0x15 for an invalid one.
  - tx_data_o is held until the WAIT_TX exit.
REQ-025 WAIT_TX SHALL return to IDLE on the cycle tx_done_tick_i=1; there is no timeout in WAIT_TX.
REQ-026 rx_done_tick_i in LOAD, ACK or WAIT_TX SHALL discard the byte and pulse overrun_o the next cycle.
REQ-027 Timeout counter (states CHAN..CSUM):
  - Cleared on entry to CHAN and on every accepted byte; otherwise increments.
  - On reaching TIMEOUT_CLK-1 with no byte that cycle: FSM->IDLE, timeout_o pulses the next cycle, no ack is sent.
  - If a byte and the terminal count coincide, the byte wins: it is accepted and the counter clears.
REQ-028 Inside a packet, 0xA5 SHALL be treated as ordinary data; there is no resynchronisation.

Reset
REQ-029 While rst_i=1, the outputs SHALL be: ch_load_o=0, ch_pattern_o=0, ch_ctrl_o=0, tx_start_o=0, tx_data_o=0x00, timeout_o=0, overrun_o=0; the FSM SHALL be in IDLE and the counters at 0.
REQ-030 Reset mid-packet or mid-transmission SHALL abandon the operation with no load and no ack; after release, operation SHALL restart at IDLE.

Verification
REQ-031 Valid packet -> load and ACK: send A5 03 12 34 56 78 81 8A -> ch_load_o=0x0008 for one cycle, ch_pattern_o=0x12345678, ch_ctrl_o=0x81; next cycle tx_start_o=1 with tx_data_o=0x06.
REQ-032 Bad checksum -> NAK only: send A5 03 12 34 56 78 81 8B -> no ch_load_o; tx_data_o=0x15; pattern and control outputs unchanged.
REQ-033 Out-of-range channel -> NAK only: send A5 10 00 00 00 00 00 10 (channel 16, OUTPUT_NUM=16) -> no load; tx_data_o=0x15.
REQ-034 Timeout, with TIMEOUT_CLK=50:
  - Send A5 05 11, then idle 50 clocks -> timeout_o pulse, no tx_start_o.
  - Then send a full valid packet -> accepted normally.
REQ-035 Overrun: send a byte 0x55 during WAIT_TX -> overrun_o pulses once; the FSM returns to IDLE on tx_done_tick_i; the next packet is decoded correctly.
REQ-036 Reset mid-packet: assert rst_i after A5 07 AA -> all outputs 0; after release, a full valid packet to channel 7 gives ch_load_o=0x0080.
